bram_port_arbiter: RTL and testbench

Shares the single port of the x/y/z point-cloud BRAMs between three requesters: the cache-fill reader, the outlier-clear writer and the feeder stream reader. One access per cycle is granted. Address, enable, write-enable and write data are broadcast identically to the three BRAMs. Read data is returned to the issuing requester with a tag-tracked valid strobe. The block sits between the BRAM-interface sequencer and the BRAM ports and replaces direct address muxing in the sequencer.

---
 rtl/bram_port_arbiter_if.sv | 63 ++++++
 rtl/bram_port_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_port_arbiter_if.sv
// bram_port_arbiter_if: bundles the requester handshakes, the broadcast BRAM
// port and the returned read data of the point-cloud BRAM arbiter.
// The master side is the surrounding system (requesters and the BRAMs);
// the slave side is the arbiter itself.
interface bram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int WE_W   = 16
);
  // Requester side
  logic              req_fill;
  logic              req_clr;
  logic              req_feed;
  logic [ADDR_W-1:0] addr_fill;
  logic [ADDR_W-1:0] addr_clr;
  logic [ADDR_W-1:0] addr_feed;
  logic [WE_W-1:0]   we_clr;
  logic [DATA_W-1:0] wdata_clr;
  logic              gnt_fill;
  logic              gnt_clr;
  logic              gnt_feed;
  logic              rvalid_fill;
  logic              rvalid_feed;
  logic [DATA_W-1:0] rdata_x;
  logic [DATA_W-1:0] rdata_y;
  logic [DATA_W-1:0] rdata_z;

  // BRAM side (shared by the x, y and z memories)
  logic [DATA_W-1:0] read_out_x;
  logic [DATA_W-1:0] read_out_y;
  logic [DATA_W-1:0] read_out_z;
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_en;
  logic [WE_W-1:0]   bram_we;
  logic [DATA_W-1:0] bram_wdata;

  // Status
  logic              idle;

  modport master (
    output req_fill, req_clr, req_feed,
    output addr_fill, addr_clr, addr_feed,
    output we_clr, wdata_clr,
    output read_out_x, read_out_y, read_out_z,
    input  gnt_fill, gnt_clr, gnt_feed,
    input  rvalid_fill, rvalid_feed,
    input  rdata_x, rdata_y, rdata_z,
    input  bram_addr, bram_en, bram_we, bram_wdata,
    input  idle
  );

  modport slave (
    input  req_fill, req_clr, req_feed,
    input  addr_fill, addr_clr, addr_feed,
    input  we_clr, wdata_clr,
    input  read_out_x, read_out_y, read_out_z,
    output gnt_fill, gnt_clr, gnt_feed,
    output rvalid_fill, rvalid_feed,
    output rdata_x, rdata_y, rdata_z,
    output bram_addr, bram_en, bram_we, bram_wdata,
    output idle
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares the single port of the x/y/z point-cloud BRAMs
// between the cache-fill reader, the outlier-clear writer and the feeder
// stream reader. One access is granted per cycle; the BRAM port and grants
// are registered, and read data is returned with a tag-tracked valid strobe.
//
// Build option: define BRAM_ARB_RR_EN to replace fixed priority
// (fill > clr > feed with feed starvation override) by round-robin
// arbitration in the order fill -> clr -> feed -> fill.
module bram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 128,
  parameter int WE_W         = 16,
  parameter int READ_LATENCY = 1,   // legal 1..3
  parameter int STARVE_LIMIT = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  bram_port_arbiter_if.slave bus
);

  // Source of an access; SRC_NONE also marks writes and empty tag slots.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_FILL = 2'd1,
    SRC_CLR  = 2'd2,
    SRC_FEED = 2'd3
  } src_e;

  src_e winner;     // requester picked at the coming edge
  src_e read_src;   // tag pushed into the read pipe at the coming edge

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef BRAM_ARB_RR_EN
  src_e rr_ptr_q;   // requester with highest priority this cycle
  src_e rr_ptr_d;

  // Round-robin pick: search fill -> clr -> feed starting at the pointer.
  always_comb begin
    winner = SRC_NONE;
    unique case (rr_ptr_q)
      SRC_CLR: begin
        if      (bus.req_clr)  winner = SRC_CLR;
        else if (bus.req_feed) winner = SRC_FEED;
        else if (bus.req_fill) winner = SRC_FILL;
      end
      SRC_FEED: begin
        if      (bus.req_feed) winner = SRC_FEED;
        else if (bus.req_fill) winner = SRC_FILL;
        else if (bus.req_clr)  winner = SRC_CLR;
      end
      default: begin
        if      (bus.req_fill) winner = SRC_FILL;
        else if (bus.req_clr)  winner = SRC_CLR;
        else if (bus.req_feed) winner = SRC_FEED;
      end
    endcase
  end

  // Pointer moves to the requester after the last winner; holds when idle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    unique case (winner)
      SRC_FILL: rr_ptr_d = SRC_CLR;
      SRC_CLR:  rr_ptr_d = SRC_FEED;
      SRC_FEED: rr_ptr_d = SRC_FILL;
      default:  rr_ptr_d = rr_ptr_q;
    endcase
  end

  // Round-robin pointer register.
  always_ff @(posedge clock) begin
    if (!reset_n) rr_ptr_q <= SRC_FILL;
    else          rr_ptr_q <= rr_ptr_d;
  end
`else
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;
  logic             starved;

  // Feed has waited STARVE_LIMIT consecutive cycles: it takes this edge.
  assign starved = bus.req_feed && (starve_q >= CNT_W'(STARVE_LIMIT));

  // Fixed priority fill > clr > feed, with the starvation override on top.
  always_comb begin
    winner = SRC_NONE;
    if      (starved)      winner = SRC_FEED;
    else if (bus.req_fill) winner = SRC_FILL;
    else if (bus.req_clr)  winner = SRC_CLR;
    else if (bus.req_feed) winner = SRC_FEED;
  end

  // Count cycles feed is requesting but losing; any feed grant or a low
  // req_feed restarts the count. It never passes the limit because the
  // override grants feed as soon as the limit is reached.
  always_comb begin
    starve_d = '0;
    if (bus.req_feed && winner != SRC_FEED) starve_d = starve_q + CNT_W'(1);
  end

  // Starvation counter register.
  always_ff @(posedge clock) begin
    if (!reset_n) starve_q <= '0;
    else          starve_q <= starve_d;
  end
`endif

  // ---------------------------------------------------------------------------
  // BRAM port and grant generation
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [WE_W-1:0]   we_q,    we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              en_q,    en_d;
  logic              gnt_fill_q, gnt_clr_q, gnt_feed_q;

  // Next BRAM command from the winner; address and write data hold when
  // nobody wins so the port does not toggle needlessly.
  // NOTE: every signal gets a default first so no path through the case
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = '0;
    en_d     = (winner != SRC_NONE);
    read_src = SRC_NONE;
    unique case (winner)
      SRC_FILL: begin
        addr_d   = bus.addr_fill;
        wdata_d  = '0;
        read_src = SRC_FILL;
      end
      SRC_CLR: begin
        addr_d  = bus.addr_clr;
        we_d    = bus.we_clr;
        wdata_d = bus.wdata_clr;
      end
      SRC_FEED: begin
        addr_d   = bus.addr_feed;
        wdata_d  = '0;
        read_src = SRC_FEED;
      end
      default: ;
    endcase
  end

  // Registered BRAM port and one-cycle grant pulses.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      addr_q     <= '0;
      we_q       <= '0;
      wdata_q    <= '0;
      en_q       <= 1'b0;
      gnt_fill_q <= 1'b0;
      gnt_clr_q  <= 1'b0;
      gnt_feed_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      en_q       <= en_d;
      gnt_fill_q <= (winner == SRC_FILL);
      gnt_clr_q  <= (winner == SRC_CLR);
      gnt_feed_q <= (winner == SRC_FEED);
    end
  end

  // ---------------------------------------------------------------------------
  // Read tag pipe: slot 0 holds the access presented to the BRAM this cycle,
  // slot READ_LATENCY-1 the one whose data appears at the next edge, where
  // the registered rvalid picks it up.
  // ---------------------------------------------------------------------------
  src_e tag_q [READ_LATENCY];
  logic rvalid_fill_q, rvalid_feed_q;
  logic pipe_empty;

  // Tag shift register and valid strobes.
  // NOTE: this small tag store is reset on purpose: a stale tag surviving
  // reset would raise rvalid for a read that was discarded.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= SRC_NONE;
      rvalid_fill_q <= 1'b0;
      rvalid_feed_q <= 1'b0;
    end else begin
      tag_q[0] <= read_src;
      for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      rvalid_fill_q <= (tag_q[READ_LATENCY-1] == SRC_FILL);
      rvalid_feed_q <= (tag_q[READ_LATENCY-1] == SRC_FEED);
    end
  end

  // True when no read is travelling through the BRAM.
  always_comb begin
    pipe_empty = 1'b1;
    for (int i = 0; i < READ_LATENCY; i++) begin
      if (tag_q[i] != SRC_NONE) pipe_empty = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.bram_addr   = addr_q;
  assign bus.bram_en     = en_q;
  assign bus.bram_we     = we_q;
  assign bus.bram_wdata  = wdata_q;
  assign bus.gnt_fill    = gnt_fill_q;
  assign bus.gnt_clr     = gnt_clr_q;
  assign bus.gnt_feed    = gnt_feed_q;
  assign bus.rvalid_fill = rvalid_fill_q;
  assign bus.rvalid_feed = rvalid_feed_q;
  assign bus.rdata_x     = bus.read_out_x;
  assign bus.rdata_y     = bus.read_out_y;
  assign bus.rdata_z     = bus.read_out_z;
  assign bus.idle        = !(bus.req_fill || bus.req_clr || bus.req_feed)
                           && pipe_empty && !en_q;

  // ---------------------------------------------------------------------------
  // Sanity properties
  // ---------------------------------------------------------------------------
  a_rvalid_exclusive : assert property (@(posedge clock) disable iff (!reset_n)
    !(rvalid_fill_q && rvalid_feed_q));

  a_gnt_onehot0 : assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0({gnt_fill_q, gnt_clr_q, gnt_feed_q}));

  a_gnt_has_en : assert property (@(posedge clock) disable iff (!reset_n)
    (gnt_fill_q || gnt_clr_q || gnt_feed_q) == en_q);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed bench for bram_port_arbiter with a
// one-cycle-latency BRAM model whose read data encodes the read address.
module tb_bram_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int WE_W   = 16;
  localparam logic [31:0] KX = 32'h1111_0000;
  localparam logic [31:0] KY = 32'h2222_0000;
  localparam logic [31:0] KZ = 32'h3333_0000;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  always #5 clock = ~clock;

  bram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WE_W(WE_W)) bus ();

  bram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WE_W(WE_W),
    .READ_LATENCY(1), .STARVE_LIMIT(16)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Content of the modelled BRAM at a given address for one axis.
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a,
                                            input logic [31:0] k);
    return {4{a ^ k}};
  endfunction

  // BRAM model: one-cycle read latency, output holds between reads.
  always @(posedge clock) begin
    if (bus.bram_en && bus.bram_we == '0) begin
      bus.read_out_x <= pat(bus.bram_addr, KX);
      bus.read_out_y <= pat(bus.bram_addr, KY);
      bus.read_out_z <= pat(bus.bram_addr, KZ);
    end
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [4:0] strobes;
    bus.req_fill = 1'b0; bus.req_clr = 1'b0; bus.req_feed = 1'b0;
    bus.addr_fill = '0; bus.addr_clr = '0; bus.addr_feed = '0;
    bus.we_clr = '0; bus.wdata_clr = '0;
    reset_n = 1'b0;
    step();
    step();
    total++;
    if (bus.bram_addr !== '0 || bus.bram_we !== '0 || bus.bram_wdata !== '0) begin
      bad++;
      $display("FAIL reset_port addr=%h we=%h wdata=%h required all zero",
               bus.bram_addr, bus.bram_we, bus.bram_wdata);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      strobes = {bus.gnt_fill, bus.gnt_clr, bus.gnt_feed, bus.rvalid_fill, bus.rvalid_feed};
      total++;
      if (bus.idle !== 1'b1) begin
        bad++; $display("FAIL reset_idle cyc=%0d got=%b required=1", i, bus.idle);
      end
      total++;
      if (bus.bram_en !== 1'b0) begin
        bad++; $display("FAIL reset_en cyc=%0d got=%b required=0", i, bus.bram_en);
      end
      total++;
      if (strobes !== 5'b0) begin
        bad++; $display("FAIL reset_strobes cyc=%0d got=%b required=00000", i, strobes);
      end
    end
  endtask

  task automatic test_fill_read();
    bus.addr_fill = 32'h10;
    bus.req_fill  = 1'b1;
    step();                                // cycle G
    total++;
    if ({bus.gnt_fill, bus.gnt_clr, bus.gnt_feed} !== 3'b100) begin
      bad++; $display("FAIL fill_gnt got=%b required=100", {bus.gnt_fill, bus.gnt_clr, bus.gnt_feed});
    end
    total++;
    if (bus.bram_addr !== 32'h10 || bus.bram_we !== '0 || bus.bram_en !== 1'b1) begin
      bad++; $display("FAIL fill_port addr=%h we=%h en=%b required 10/0/1",
                      bus.bram_addr, bus.bram_we, bus.bram_en);
    end
    total++;
    if (bus.idle !== 1'b0) begin
      bad++; $display("FAIL fill_idle_busy got=%b required=0", bus.idle);
    end
    bus.req_fill = 1'b0;
    step();                                // cycle G+1
    total++;
    if ({bus.rvalid_fill, bus.rvalid_feed} !== 2'b10) begin
      bad++; $display("FAIL fill_rvalid got=%b required=10", {bus.rvalid_fill, bus.rvalid_feed});
    end
    total++;
    if (bus.rdata_x !== pat(32'h10, KX) || bus.rdata_y !== pat(32'h10, KY) ||
        bus.rdata_z !== pat(32'h10, KZ)) begin
      bad++; $display("FAIL fill_rdata x=%h required=%h", bus.rdata_x, pat(32'h10, KX));
    end
    total++;
    if (bus.bram_en !== 1'b0 || bus.gnt_fill !== 1'b0) begin
      bad++; $display("FAIL fill_release en=%b gnt=%b required 0/0", bus.bram_en, bus.gnt_fill);
    end
    step();                                // cycle G+2
    total++;
    if (bus.rvalid_fill !== 1'b0 || bus.idle !== 1'b1) begin
      bad++; $display("FAIL fill_drain rvalid=%b idle=%b required 0/1", bus.rvalid_fill, bus.idle);
    end
  endtask

  task automatic test_clr_write();
    bus.addr_clr  = 32'h05;
    bus.we_clr    = 16'h00ff;
    bus.wdata_clr = '0;
    bus.req_clr   = 1'b1;
    step();                                // cycle G
    total++;
    if ({bus.gnt_fill, bus.gnt_clr, bus.gnt_feed} !== 3'b010) begin
      bad++; $display("FAIL clr_gnt got=%b required=010", {bus.gnt_fill, bus.gnt_clr, bus.gnt_feed});
    end
    total++;
    if (bus.bram_addr !== 32'h05 || bus.bram_we !== 16'h00ff || bus.bram_wdata !== '0 ||
        bus.bram_en !== 1'b1) begin
      bad++; $display("FAIL clr_port addr=%h we=%h en=%b required 05/00ff/1",
                      bus.bram_addr, bus.bram_we, bus.bram_en);
    end
    bus.req_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if ({bus.rvalid_fill, bus.rvalid_feed} !== 2'b00) begin
        bad++; $display("FAIL clr_no_rvalid cyc=%0d got=%b required=00", i,
                        {bus.rvalid_fill, bus.rvalid_feed});
      end
    end
    total++;
    if (bus.bram_addr !== 32'h05 || bus.bram_we !== '0 || bus.bram_en !== 1'b0) begin
      bad++; $display("FAIL clr_hold addr=%h we=%h en=%b required 05/0/0",
                      bus.bram_addr, bus.bram_we, bus.bram_en);
    end
  endtask

  task automatic test_all_three();
    logic [2:0]        exp_gnt [4];
    logic [1:0]        exp_rv  [4];
    logic [ADDR_W-1:0] exp_adr [4];
    logic [ADDR_W-1:0] exp_rd  [4];
    exp_gnt = '{3'b100, 3'b010, 3'b001, 3'b000};
    exp_rv  = '{2'b00, 2'b10, 2'b00, 2'b01};
    exp_adr = '{32'h20, 32'h21, 32'h22, 32'h22};
    exp_rd  = '{32'h0, 32'h20, 32'h0, 32'h22};
    apply_reset();
    bus.addr_fill = 32'h20; bus.addr_clr = 32'h21; bus.addr_feed = 32'h22;
    bus.we_clr = 16'hffff; bus.wdata_clr = 128'hdead_beef;
    bus.req_fill = 1'b1; bus.req_clr = 1'b1; bus.req_feed = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if ({bus.gnt_fill, bus.gnt_clr, bus.gnt_feed} !== exp_gnt[c]) begin
        bad++; $display("FAIL all3_gnt cyc=%0d got=%b required=%b", c,
                        {bus.gnt_fill, bus.gnt_clr, bus.gnt_feed}, exp_gnt[c]);
      end
      total++;
      if (bus.bram_addr !== exp_adr[c]) begin
        bad++; $display("FAIL all3_addr cyc=%0d got=%h required=%h", c, bus.bram_addr, exp_adr[c]);
      end
      total++;
      if ({bus.rvalid_fill, bus.rvalid_feed} !== exp_rv[c]) begin
        bad++; $display("FAIL all3_rvalid cyc=%0d got=%b required=%b", c,
                        {bus.rvalid_fill, bus.rvalid_feed}, exp_rv[c]);
      end
      if (exp_rv[c] != 2'b00) begin
        total++;
        if (bus.rdata_x !== pat(exp_rd[c], KX)) begin
          bad++; $display("FAIL all3_rdata cyc=%0d got=%h required=%h", c, bus.rdata_x,
                          pat(exp_rd[c], KX));
        end
      end
      if (bus.gnt_fill) bus.req_fill = 1'b0;
      if (bus.gnt_clr)  bus.req_clr  = 1'b0;
      if (bus.gnt_feed) bus.req_feed = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    bus.addr_fill = 32'h40;
    bus.req_fill  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (bus.gnt_fill !== (i < 3) || (i < 3 && bus.bram_addr !== 32'h40 + i)) begin
        bad++; $display("FAIL b2b_gnt cyc=%0d gnt=%b addr=%h required %b/%h", i,
                        bus.gnt_fill, bus.bram_addr, (i < 3), 32'h40 + i);
      end
      total++;
      if (bus.rvalid_fill !== (i > 0)) begin
        bad++; $display("FAIL b2b_rvalid cyc=%0d got=%b required=%b", i, bus.rvalid_fill, (i > 0));
      end
      if (i > 0) begin
        total++;
        if (bus.rdata_y !== pat(32'h40 + i - 1, KY)) begin
          bad++; $display("FAIL b2b_rdata cyc=%0d got=%h required=%h", i, bus.rdata_y,
                          pat(32'h40 + i - 1, KY));
        end
      end
      bus.addr_fill = 32'h41 + i;
      if (i == 2) bus.req_fill = 1'b0;
    end
  endtask

`ifndef BRAM_ARB_RR_EN
  task automatic test_starvation();
    int first_feed = 0;
    int fill_cnt   = 0;
    bus.addr_fill = 32'h50; bus.addr_feed = 32'h33;
    bus.req_fill  = 1'b1;   bus.req_feed  = 1'b1;
    for (int c = 1; c <= 30 && first_feed == 0; c++) begin
      step();
      if (bus.gnt_feed) begin
        first_feed   = c;
        bus.req_feed = 1'b0;
      end else if (bus.gnt_fill) begin
        fill_cnt++;
      end
    end
    total++;
    if (first_feed != 17) begin
      bad++; $display("FAIL starve_cycle got=%0d required=17 (0 means never)", first_feed);
    end
    total++;
    if (fill_cnt != 16) begin
      bad++; $display("FAIL starve_fill_count got=%0d required=16", fill_cnt);
    end
    step();
    total++;
    if (bus.gnt_fill !== 1'b1 || bus.rvalid_feed !== 1'b1) begin
      bad++; $display("FAIL starve_resume gnt_fill=%b rvalid_feed=%b required 1/1",
                      bus.gnt_fill, bus.rvalid_feed);
    end
    total++;
    if (bus.rdata_z !== pat(32'h33, KZ)) begin
      bad++; $display("FAIL starve_rdata got=%h required=%h", bus.rdata_z, pat(32'h33, KZ));
    end
    bus.req_fill = 1'b0;
    step();
    step();
  endtask
`else
  task automatic test_round_robin();
    int         cnt [3];
    logic [2:0] exp_g;
    cnt = '{0, 0, 0};
    apply_reset();
    bus.addr_fill = 32'h60; bus.addr_clr = 32'h61; bus.addr_feed = 32'h62;
    bus.req_fill = 1'b1; bus.req_clr = 1'b1; bus.req_feed = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step();
      exp_g = 3'b100 >> (c % 3);
      total++;
      if ({bus.gnt_fill, bus.gnt_clr, bus.gnt_feed} !== exp_g) begin
        bad++; $display("FAIL rr_gnt cyc=%0d got=%b required=%b", c,
                        {bus.gnt_fill, bus.gnt_clr, bus.gnt_feed}, exp_g);
      end
      if (bus.gnt_fill) cnt[0]++;
      if (bus.gnt_clr)  cnt[1]++;
      if (bus.gnt_feed) cnt[2]++;
    end
    total++;
    if (cnt[0] != 3 || cnt[1] != 3 || cnt[2] != 3) begin
      bad++; $display("FAIL rr_share fill=%0d clr=%0d feed=%0d required 3/3/3",
                      cnt[0], cnt[1], cnt[2]);
    end
    bus.req_fill = 1'b0; bus.req_clr = 1'b0; bus.req_feed = 1'b0;
    step();
    step();
  endtask
`endif

  task automatic test_reset_midstream();
    bus.addr_fill = 32'h70;
    bus.req_fill  = 1'b1;
    step();                                // fill granted, read in flight
    total++;
    if (bus.gnt_fill !== 1'b1) begin
      bad++; $display("FAIL mid_gnt got=%b required=1", bus.gnt_fill);
    end
    bus.req_fill = 1'b0;
    bus.addr_clr = 32'h71;
    bus.req_clr  = 1'b1;                   // pending across reset
    reset_n      = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({bus.gnt_fill, bus.gnt_clr, bus.gnt_feed, bus.rvalid_fill, bus.rvalid_feed,
           bus.bram_en} !== 6'b0) begin
        bad++; $display("FAIL mid_reset cyc=%0d gnt=%b rvalid=%b en=%b required all 0", i,
                        {bus.gnt_fill, bus.gnt_clr, bus.gnt_feed},
                        {bus.rvalid_fill, bus.rvalid_feed}, bus.bram_en);
      end
    end
    reset_n = 1'b1;
    step();
    total++;
    if (bus.gnt_clr !== 1'b1 || bus.bram_addr !== 32'h71) begin
      bad++; $display("FAIL mid_rearb gnt_clr=%b addr=%h required 1/71", bus.gnt_clr,
                      bus.bram_addr);
    end
    bus.req_clr = 1'b0;
    step();
    total++;
    if ({bus.rvalid_fill, bus.rvalid_feed} !== 2'b00) begin
      bad++; $display("FAIL mid_no_rvalid got=%b required=00", {bus.rvalid_fill, bus.rvalid_feed});
    end
  endtask

  initial begin
    bus.read_out_x = '0;
    bus.read_out_y = '0;
    bus.read_out_z = '0;
    test_reset();
    test_fill_read();
    test_clr_write();
    test_all_three();
    test_back_to_back();
`ifndef BRAM_ARB_RR_EN
    test_starvation();
`else
    test_round_robin();
`endif
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
